// File: rtl/bw_div_pkg.sv
// Shared types and sizing helpers for the bw_div sequential signed divider.
// State encoding plus the iteration-count and latency constants derived from BW.
package bw_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One restoring iteration per dividend bit.
    function automatic int iter_count(input int bw);
        return 2 * bw - 1;
    endfunction

    // Clocks from the accepting edge to out_valid for a non-zero divisor.
    function automatic int latency(input int bw);
        return 2 * bw + 1;
    endfunction

endpackage

// File: rtl/bw_div_cneg.sv
// Conditional two's-complement negate: y = neg ? -a : a, at width W.
// Used for operand magnitudes and for the final sign correction.
module bw_cneg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign y = neg ? (~a + ONE) : a;

endmodule

// File: rtl/bw_div.sv
// Sequential radix-2 restoring signed divider: (2*BW-1)-bit dividend / BW-bit divisor.
// Define BW_DIV_SAT_EN to saturate the quotient (and zero the remainder) on overflow.
module bw_div
    import bw_div_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*BW-2:0] dividend,
    input  logic [BW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BW-1:0]   quotient,
    output logic [BW-1:0]   remainder,
    output logic            ovf,
    output logic            dbz
);

    localparam int NW    = 2 * BW - 1;
    localparam int NITER = iter_count(BW);
    localparam int CW    = $clog2(NITER + 1);

    localparam logic [NW-1:0] QMAG_POS_MAX = NW'((1 << (BW - 1)) - 1);
    localparam logic [NW-1:0] QMAG_NEG_MAX = NW'(1 << (BW - 1));
`ifdef BW_DIV_SAT_EN
    localparam logic [BW-1:0] Q_SAT_POS = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0] Q_SAT_NEG = {1'b1, {(BW-1){1'b0}}};
`endif

    state_t          state;
    logic [NW-1:0]   nmag;      // dividend magnitude shifts out MSB-first, quotient bits shift in
    logic [BW-1:0]   dmag;
    logic [BW-1:0]   rmag;
    logic            sd;
    logic            sq;
    logic [CW-1:0]   cnt;

    logic [NW-1:0]   dividend_abs;
    logic [BW-1:0]   divisor_abs;
    logic [BW-1:0]   q_signed;
    logic [BW-1:0]   r_signed;

    logic [BW-1:0]   shifted;
    logic [BW:0]     trial;
    logic            qbit;
    logic [BW-1:0]   rmag_next;
    logic            ovf_calc;

    bw_cneg #(.W(NW)) u_abs_dividend (
        .a   (dividend),
        .neg (dividend[NW-1]),
        .y   (dividend_abs)
    );

    bw_cneg #(.W(BW)) u_abs_divisor (
        .a   (divisor),
        .neg (divisor[BW-1]),
        .y   (divisor_abs)
    );

    // Low BW bits of -qmag equal the negation of its low BW bits.
    bw_cneg #(.W(BW)) u_fix_quotient (
        .a   (nmag[BW-1:0]),
        .neg (sq),
        .y   (q_signed)
    );

    bw_cneg #(.W(BW)) u_fix_remainder (
        .a   (rmag),
        .neg (sd),
        .y   (r_signed)
    );

    // Partial remainder stays below |divisor| <= 2^(BW-1), so its MSB is always
    // clear and the shifted value fits in BW bits; one extra bit carries the borrow.
    assign shifted   = {rmag[BW-2:0], nmag[NW-1]};
    assign trial     = {1'b0, shifted} - {1'b0, dmag};
    assign qbit      = ~trial[BW];
    assign rmag_next = qbit ? trial[BW-1:0] : shifted;

    // qmag == 0 compares false in both arms, so a zero quotient never overflows.
    assign ovf_calc  = sq ? (nmag > QMAG_NEG_MAX) : (nmag > QMAG_POS_MAX);

    // NOTE: every register here is sequential state, so all updates use
    // non-blocking assignments and are cleared by the asynchronous reset,
    // which also discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            nmag      <= '0;
            dmag      <= '0;
            rmag      <= '0;
            sd        <= 1'b0;
            sq        <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sd       <= dividend[NW-1];
                        sq       <= dividend[NW-1] ^ divisor[BW-1];
                        nmag     <= dividend_abs;
                        dmag     <= divisor_abs;
                        rmag     <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient  <= '0;
                            remainder <= '0;
                            ovf       <= 1'b1;
                            dbz       <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= CW'(NITER);
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    nmag <= {nmag[NW-2:0], qbit};
                    rmag <= rmag_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    ovf <= ovf_calc;
                    dbz <= 1'b0;
`ifdef BW_DIV_SAT_EN
                    if (ovf_calc) begin
                        quotient  <= sq ? Q_SAT_NEG : Q_SAT_POS;
                        remainder <= '0;
                    end else begin
                        quotient  <= q_signed;
                        remainder <= r_signed;
                    end
`else
                    quotient  <= q_signed;
                    remainder <= r_signed;
`endif
                    state <= DONE;
                end

                DONE: begin
                    // out_valid rises on the first DONE edge, so results are
                    // settled a full cycle before the consumer sees them.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_div.sv
// Directed self-checking bench for bw_div at BW=8 (both default and BW_DIV_SAT_EN builds).
// Table-driven vectors plus hand-written backpressure and mid-operation reset sequences.
module tb_bw_div;

    localparam int BW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2*BW-2:0] dividend;
    logic [BW-1:0]   divisor;
    logic            out_valid;
    logic            out_ready;
    logic [BW-1:0]   quotient;
    logic [BW-1:0]   remainder;
    logic            ovf;
    logic            dbz;

    int checks;
    int errors;

    bw_div #(.BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  b;
        logic [7:0]  q;    // expected quotient, wrapping build
        logic [7:0]  r;
        logic [7:0]  qs;   // expected quotient, saturating build
        logic [7:0]  rs;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one operation, wait for acceptance, then count clocks to out_valid.
    task automatic run_op(input logic [14:0] a, input logic [7:0] b, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int lat;
        int seen;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        //           dividend  divisor  q      r      q_sat  r_sat  ovf   dbz   lat
        vecs[0]  = '{15'h0015, 8'h04, 8'h05, 8'h01, 8'h05, 8'h01, 1'b0, 1'b0, 17}; // 21/4
        vecs[1]  = '{15'h7FEB, 8'h04, 8'hFB, 8'hFF, 8'hFB, 8'hFF, 1'b0, 1'b0, 17}; // -21/4
        vecs[2]  = '{15'h0015, 8'hFC, 8'hFB, 8'h01, 8'hFB, 8'h01, 1'b0, 1'b0, 17}; // 21/-4
        vecs[3]  = '{15'h7FEB, 8'hFC, 8'h05, 8'hFF, 8'h05, 8'hFF, 1'b0, 1'b0, 17}; // -21/-4
        vecs[4]  = '{15'h3F80, 8'h81, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0, 17}; // 16256/-127 = -128
        vecs[5]  = '{15'h4000, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h00, 1'b1, 1'b0, 17}; // -16384/-128 = 128
        vecs[6]  = '{15'h7F80, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'h00, 1'b1, 1'b0, 17}; // -128/-1
        vecs[7]  = '{15'h0064, 8'hFF, 8'h9C, 8'h00, 8'h9C, 8'h00, 1'b0, 1'b0, 17}; // 100/-1
        vecs[8]  = '{15'h03E8, 8'h02, 8'hF4, 8'h00, 8'h7F, 8'h00, 1'b1, 1'b0, 17}; // 1000/2 = 500
        vecs[9]  = '{15'h7EFE, 8'h02, 8'h7F, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 17}; // -258/2 = -129
        vecs[10] = '{15'h3FFF, 8'h80, 8'h81, 8'h7F, 8'h81, 8'h7F, 1'b0, 1'b0, 17}; // 16383/-128
        vecs[11] = '{15'h7FF9, 8'h03, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 1'b0, 1'b0, 17}; // -7/3
        vecs[12] = '{15'h007B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1};  // 123/0
        vecs[13] = '{15'h0000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 17}; // 0/5

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
`ifdef BW_DIV_SAT_EN
            check($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].qs));
            check($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].rs));
`else
            check($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
`endif
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            check($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
            check($sformatf("v%0d_in_ready_busy", i), 32'(in_ready), 32'd0);
            finish_op($sformatf("v%0d", i));
        end

        // Backpressure: results held, new input ignored while out_ready is low
        run_op(15'h0015, 8'h04, lat);
        check("bp_latency", 32'(lat), 32'd17);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 15'h03E8;
            divisor  = 8'h03;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_quotient", c), 32'(quotient), 32'h05);
            check($sformatf("bp%0d_remainder", c), 32'(remainder), 32'h01);
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_op("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_quotient_held", 32'(quotient), 32'h05);

        // Reset during CALC: outputs clear at once and no result ever appears
        @(negedge clk);
        dividend = 15'h7FEB;
        divisor  = 8'h04;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_op(15'h0015, 8'h04, lat);
        check("post_rst_latency", 32'(lat), 32'd17);
        check("post_rst_quotient", 32'(quotient), 32'h05);
        check("post_rst_remainder", 32'(remainder), 32'h01);
        check("post_rst_ovf", 32'(ovf), 32'd0);
        finish_op("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
